// File: rtl/deco_7seg_mux_n_if.sv
// deco_7seg_mux_n_if: display controller bus between datapath and scan unit.
// master drives Enable/Load/Valor/Punto; slave drives Segmentos/Punto/Anodos/Tick.
interface deco_7seg_mux_n_if #(
  parameter int N_DIGITS = 4
);
  logic                  i_Enable;
  logic                  i_Load;
  logic [4*N_DIGITS-1:0] i_Valor;
  logic [N_DIGITS-1:0]   i_Punto;
  logic [6:0]            o_Segmentos;
  logic                  o_Punto;
  logic [N_DIGITS-1:0]   o_Anodos;
  logic                  o_Tick;

  modport master (
    output i_Enable, i_Load, i_Valor, i_Punto,
    input  o_Segmentos, o_Punto, o_Anodos, o_Tick
  );

  modport slave (
    input  i_Enable, i_Load, i_Valor, i_Punto,
    output o_Segmentos, o_Punto, o_Anodos, o_Tick
  );
endinterface

// File: rtl/deco_7seg_mux_n.sv
// deco_7seg_mux_n: N-digit multiplexed 7-seg driver, double-buffered values.
// Ports: i_Clk, i_Reset (sync, high), bus (slave). Macro BLANK_CEROS_EN.
module deco_7seg_mux_n #(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic               i_Clk,
  input logic               i_Reset,
  deco_7seg_mux_n_if.slave  bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [VW-1:0]       pval_q, pval_d;
  logic [N_DIGITS-1:0] pdp_q, pdp_d;
  logic [VW-1:0]       dval_q, dval_d;
  logic [N_DIGITS-1:0] ddp_q, ddp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                tick_q, tick_d;

  logic                adv;
  logic                wrap;
  logic                bnd;
  logic                blank;
  logic [3:0]          nib;
  logic [6:0]          pat;
  logic [N_DIGITS-1:0] onehot;
  logic [N_DIGITS-1:0] nz;
  logic                hi;
  int                  sel;

  always_comb begin
    adv     = bus.i_Enable && (presc_q == P_LAST);
    wrap    = (idx_q == I_LAST);
    bnd     = adv && wrap;
    sel     = int'(idx_q);

    presc_d = presc_q;
    if (bus.i_Enable) begin
      presc_d = adv ? '0 : presc_q + 1'b1;
    end

    idx_d = idx_q;
    if (adv) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    pval_d = bus.i_Load ? bus.i_Valor : pval_q;
    pdp_d  = bus.i_Load ? bus.i_Punto : pdp_q;

    // A load on the frame edge bypasses pending so it shows immediately.
    dval_d = dval_q;
    ddp_d  = ddp_q;
    if (bnd) begin
      dval_d = bus.i_Load ? bus.i_Valor : pval_q;
      ddp_d  = bus.i_Load ? bus.i_Punto : pdp_q;
    end

    // nz[k]: digit k or any higher digit is non-zero.
    nz = '0;
    hi = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      hi    = hi | (|dval_q[4*k +: 4]);
      nz[k] = hi;
    end

`ifdef BLANK_CEROS_EN
    blank = (sel != 0) && !nz[sel];
`else
    blank = 1'b0;
`endif

    nib = dval_q[4*sel +: 4];
    pat = hex7(nib);

    onehot      = '0;
    onehot[sel] = 1'b1;

    seg_d  = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~pat : pat);
    dp_d   = SEG_ACTIVE_LOW ? ~ddp_q[sel] : ddp_q[sel];
    an_d   = AN_ACTIVE_LOW ? ~onehot : onehot;
    tick_d = adv;

    if (!bus.i_Enable) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      an_d  = AN_OFF;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pval_q  <= '0;
      pdp_q   <= '0;
      dval_q  <= '0;
      ddp_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pval_q  <= pval_d;
      pdp_q   <= pdp_d;
      dval_q  <= dval_d;
      ddp_q   <= ddp_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.o_Segmentos = seg_q;
  assign bus.o_Punto     = dp_q;
  assign bus.o_Anodos    = an_q;
  assign bus.o_Tick      = tick_q;
endmodule
